// File: rtl/q_meter_pkg.sv
// Shared types, defaults and helpers for the q_meter ring-down measurement block.
package q_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRing,
        StDone
    } q_state_t;

    localparam int unsigned Q_SETTLE_CYC_DEF = 64;
    localparam int unsigned Q_GAP_CYC_DEF    = 16;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/q_meter.sv
// Q estimator: excite the resonator, then count ring-down comparator edges until a quiet gap.
// Define Q_METER_AVG_EN to average two consecutive runs per measurement.
module q_meter
    import q_meter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 10,
    parameter int unsigned SETTLE_CYC = Q_SETTLE_CYC_DEF,
    parameter int unsigned GAP_CYC    = Q_GAP_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 comp_in,
    output logic                 excite,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 saturated
);

    localparam int unsigned SW = cnt_w(SETTLE_CYC);
    localparam int unsigned GW = cnt_w(GAP_CYC);
    localparam logic [SW-1:0]        SettleLast = SW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0]        GapLast    = GW'(GAP_CYC - 1);
    localparam logic [BUS_WIDTH-1:0] CntMax     = '1;

    q_state_t             state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clip_q, clip_d;
    logic [BUS_WIDTH-1:0] ref_q, ref_d;
    logic [BUS_WIDTH-1:0] q_q, q_d;
    logic                 sat_q, sat_d;
    logic                 ready_q, ready_d;
    logic                 excite_q, excite_d;
    logic                 en_q;
    logic                 comp_s, comp_prev_q, edge_q;
    logic                 changed, restart;
`ifdef Q_METER_AVG_EN
    logic                 run_q, run_d;
    logic [BUS_WIDTH-1:0] c1_q, c1_d;
    logic                 clip1_q, clip1_d;
    logic [BUS_WIDTH:0]   avg_sum;

    assign avg_sum = {1'b0, c1_q} + {1'b0, cnt_q} + {{BUS_WIDTH{1'b0}}, 1'b1};
`endif

    sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (comp_in),
        .q_o    (comp_s)
    );

    assign changed = (i_ref != ref_q);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        clip_d   = clip_q;
        ref_d    = ref_q;
        q_d      = q_q;
        sat_d    = sat_q;
        ready_d  = ready_q;
        restart  = 1'b0;
`ifdef Q_METER_AVG_EN
        run_d    = run_q;
        c1_d     = c1_q;
        clip1_d  = clip1_q;
`endif
        unique case (state_q)
            StIdle: restart = enable && (changed || !en_q);
            StSettle: begin
                if (changed) begin
                    restart = 1'b1;
                end else if (settle_q == SettleLast) begin
                    state_d = StRing;
                    cnt_d   = '0;
                    gap_d   = '0;
                    clip_d  = 1'b0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StRing: begin
                if (changed) begin
                    restart = 1'b1;
                end else if (edge_q) begin
                    // An edge on the gap terminal cycle still keeps the run alive.
                    gap_d = '0;
                    if (cnt_q == CntMax) clip_d = 1'b1;
                    else                 cnt_d  = cnt_q + 1'b1;
                end else if (gap_q == GapLast) begin
`ifdef Q_METER_AVG_EN
                    if (!run_q) begin
                        run_d    = 1'b1;
                        c1_d     = cnt_q;
                        clip1_d  = clip_q;
                        state_d  = StSettle;
                        settle_d = '0;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone: begin
`ifdef Q_METER_AVG_EN
                q_d   = BUS_WIDTH'(avg_sum >> 1);
                sat_d = clip1_q | clip_q;
`else
                q_d   = cnt_q;
                sat_d = clip_q;
`endif
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (restart) begin
            state_d  = StSettle;
            settle_d = '0;
            ref_d    = i_ref;
            ready_d  = 1'b0;
`ifdef Q_METER_AVG_EN
            run_d    = 1'b0;
`endif
        end

        if (!enable) begin
            state_d = StIdle;
            ready_d = 1'b0;
            ref_d   = ref_q;
            q_d     = q_q;
            sat_d   = sat_q;
        end

        // Registered so excite trails the SETTLE state by one cycle.
        excite_d = enable && (state_q == StSettle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            clip_q      <= 1'b0;
            ref_q       <= '0;
            q_q         <= '0;
            sat_q       <= 1'b0;
            ready_q     <= 1'b0;
            excite_q    <= 1'b0;
            en_q        <= 1'b0;
            comp_prev_q <= 1'b0;
            edge_q      <= 1'b0;
`ifdef Q_METER_AVG_EN
            run_q       <= 1'b0;
            c1_q        <= '0;
            clip1_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            clip_q      <= clip_d;
            ref_q       <= ref_d;
            q_q         <= q_d;
            sat_q       <= sat_d;
            ready_q     <= ready_d;
            excite_q    <= excite_d;
            en_q        <= enable;
            comp_prev_q <= comp_s;
            edge_q      <= comp_s & ~comp_prev_q;
`ifdef Q_METER_AVG_EN
            run_q       <= run_d;
            c1_q        <= c1_d;
            clip1_q     <= clip1_d;
`endif
        end
    end

    assign excite     = excite_q;
    assign q_measured = q_q;
    assign ready      = ready_q;
    assign saturated  = sat_q;

endmodule
